i2c_bit_frame_counter: RTL and testbench

- Parametrised successor to the single-purpose bit counter in the I2C datapath.
- Counts qualified SCL bit strobes per byte frame (data bits + ACK slot) and tracks frame position.
- Emits registered "register full" and "frame done" pulses, and counts frames between START and STOP.
- Sits between the SCL edge detector and the shift register / ACK logic. Everything runs in one clock domain; SCL edges arrive as single-cycle strobes.

---
 rtl/i2c_bit_frame_counter_pkg.sv | 25 ++
 rtl/i2c_bit_frame_counter_sat_counter.sv | 37 +++
 rtl/i2c_bit_frame_counter.sv | 142 ++++++++++++++
 tb/tb_i2c_bit_frame_counter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bit_frame_counter_pkg.sv
// Shared state encoding, default frame geometry and sizing helper for the I2C bit/frame counter.
package i2c_bit_frame_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ACK  = 2'd2
   } i2c_state_e;

   localparam int I2C_DATA_BITS = 8;
   localparam int I2C_ACK_BITS  = 1;

   // Smallest width whose range reaches the highest bit index used in a frame.
   function automatic int i2c_min_cnt_w(input int data_bits, input int ack_bits);
      int top_idx;
      int w;
      top_idx = data_bits + ack_bits - 1;
      w = 1;
      while ((1 << w) <= top_idx) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/i2c_bit_frame_counter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment); registered count.
// One-cycle update latency; increments arriving at the ceiling are dropped, never wrapped.
module i2c_bit_frame_counter_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = &cnt_q;

endmodule

// File: rtl/i2c_bit_frame_counter.sv
// Counts qualified SCL bit strobes per byte frame (data + ACK), tracks frame position and frames since START.
// All outputs registered; reg_full/frame_done pulse one clk after the completing tick. No backpressure: strobes are taken or discarded each cycle.
module i2c_bit_frame_counter
   import i2c_bit_frame_counter_pkg::*;
#(
   parameter int DATA_BITS   = I2C_DATA_BITS,
   parameter int ACK_BITS    = I2C_ACK_BITS,
   parameter int CNT_W       = 4,
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   bit_tick,
   input  logic                   start_det,
   input  logic                   stop_det,
   output logic [CNT_W-1:0]       bit_cnt,
   output logic                   data_phase,
   output logic                   ack_phase,
   output logic                   reg_full,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] ACK_IDX       = CNT_W'(DATA_BITS);

   i2c_state_e       state_q;
   i2c_state_e       state_d;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [CNT_W-1:0] bit_cnt_d;
   logic             reg_full_q;
   logic             reg_full_d;
   logic             frame_done_q;
   logic             frame_done_d;
   logic             data_phase_q;
   logic             data_phase_d;
   logic             ack_phase_q;
   logic             ack_phase_d;
   logic             busy_q;
   logic             busy_d;

   logic tick_vld;
   logic data_last;
   logic frame_end;
   logic frame_clr;
   logic frame_inc;
   logic frame_sat;

   assign tick_vld = bit_tick & en;

   // STOP beats START beats tick; a discarded tick leaves no trace.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      data_last = 1'b0;
      frame_end = 1'b0;
      frame_clr = 1'b0;
      if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = DATA;
         bit_cnt_d = '0;
         frame_clr = 1'b1;
      end else if (tick_vld) begin
         case (state_q)
            DATA: begin
               if (bit_cnt_q == LAST_DATA_IDX) begin
                  data_last = 1'b1;
                  if (ACK_BITS != 0) begin
                     state_d   = ACK;
                     bit_cnt_d = ACK_IDX;
                  end else begin
                     bit_cnt_d = '0;
                     frame_end = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            ACK: begin
               state_d   = DATA;
               bit_cnt_d = '0;
               frame_end = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Only a 1-bit, no-ACK frame can complete on consecutive ticks; its pulses are thinned, the count is not.
   always_comb begin
      reg_full_d   = data_last & ~reg_full_q;
      frame_done_d = frame_end & ~frame_done_q;
      frame_inc    = frame_end & ~frame_sat;
      data_phase_d = (state_d == DATA);
      ack_phase_d  = (state_d == ACK);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         reg_full_q   <= 1'b0;
         frame_done_q <= 1'b0;
         data_phase_q <= 1'b0;
         ack_phase_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         reg_full_q   <= reg_full_d;
         frame_done_q <= frame_done_d;
         data_phase_q <= data_phase_d;
         ack_phase_q  <= ack_phase_d;
         busy_q       <= busy_d;
      end
   end

   i2c_bit_frame_counter_sat_counter #(
      .W (FRAME_CNT_W)
   ) u_frame_cnt (
      .clk (clk),
      .rst (rst),
      .clr (frame_clr),
      .inc (frame_inc),
      .cnt (frame_cnt),
      .sat (frame_sat)
   );

   assign bit_cnt    = bit_cnt_q;
   assign data_phase = data_phase_q;
   assign ack_phase  = ack_phase_q;
   assign reg_full   = reg_full_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_bit_frame_counter.sv
// Bench for i2c_bit_frame_counter: default build, a 2-bit frame counter build and an ACK-less build share one stimulus.
module tb_i2c_bit_frame_counter;

   typedef struct packed {
      logic [31:0] cyc;
      logic        rf;
      logic        fd;
      logic [3:0]  bcnt;
      logic [7:0]  fcnt;
      logic        ack;
      logic        busy;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic bit_tick = 1'b0;
   logic start_det = 1'b0;
   logic stop_det = 1'b0;

   logic [3:0] m_bit_cnt;
   logic       m_data_phase, m_ack_phase, m_reg_full, m_frame_done, m_busy;
   logic [7:0] m_frame_cnt;
   logic [3:0] s_bit_cnt;
   logic       s_data_phase, s_ack_phase, s_reg_full, s_frame_done, s_busy;
   logic [1:0] s_frame_cnt;
   logic [3:0] n_bit_cnt;
   logic       n_data_phase, n_ack_phase, n_reg_full, n_frame_done, n_busy;
   logic [7:0] n_frame_cnt;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int          adj_cnt = 0;
   logic        prev_rf = 1'b0;
   logic        prev_fd = 1'b0;
   ev_t         exp_q[$];
   ev_t         obs_q[$];
   ev_t         exp_na_q[$];
   ev_t         obs_na_q[$];

   i2c_bit_frame_counter dut (
      .clk(clk), .rst(rst), .en(en), .bit_tick(bit_tick), .start_det(start_det), .stop_det(stop_det),
      .bit_cnt(m_bit_cnt), .data_phase(m_data_phase), .ack_phase(m_ack_phase), .reg_full(m_reg_full),
      .frame_done(m_frame_done), .frame_cnt(m_frame_cnt), .busy(m_busy)
   );

   i2c_bit_frame_counter #(.FRAME_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .bit_tick(bit_tick), .start_det(start_det), .stop_det(stop_det),
      .bit_cnt(s_bit_cnt), .data_phase(s_data_phase), .ack_phase(s_ack_phase), .reg_full(s_reg_full),
      .frame_done(s_frame_done), .frame_cnt(s_frame_cnt), .busy(s_busy)
   );

   i2c_bit_frame_counter #(.ACK_BITS(0)) dut_na (
      .clk(clk), .rst(rst), .en(en), .bit_tick(bit_tick), .start_det(start_det), .stop_det(stop_det),
      .bit_cnt(n_bit_cnt), .data_phase(n_data_phase), .ack_phase(n_ack_phase), .reg_full(n_reg_full),
      .frame_done(n_frame_done), .frame_cnt(n_frame_cnt), .busy(n_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_reg_full || m_frame_done)
         obs_q.push_back('{cyc: cyc, rf: m_reg_full, fd: m_frame_done, bcnt: m_bit_cnt,
                           fcnt: m_frame_cnt, ack: m_ack_phase, busy: m_busy});
      if (n_reg_full || n_frame_done)
         obs_na_q.push_back('{cyc: cyc, rf: n_reg_full, fd: n_frame_done, bcnt: n_bit_cnt,
                              fcnt: n_frame_cnt, ack: n_ack_phase, busy: n_busy});
      if ((m_reg_full && prev_rf) || (m_frame_done && prev_fd))
         adj_cnt <= adj_cnt + 1;
      prev_rf <= m_reg_full;
      prev_fd <= m_frame_done;
   end

   initial begin
      #300000;
      $display("FAIL timeout: still running at %0t, required to finish earlier", $time);
      $fatal(1, "bench timeout");
   end

   function automatic ev_t mk_ev(input int unsigned c, input logic rf, input logic fd,
                                 input logic [3:0] b, input logic [7:0] f, input logic a);
      ev_t e;
      e.cyc  = c;
      e.rf   = rf;
      e.fd   = fd;
      e.bcnt = b;
      e.fcnt = f;
      e.ack  = a;
      e.busy = 1'b1;
      return e;
   endfunction

   task automatic clk_cycle(input logic t, input logic s, input logic p, input logic r);
      bit_tick  = t;
      start_det = s;
      stop_det  = p;
      rst       = r;
      @(posedge clk);
      #1;
      bit_tick  = 1'b0;
      start_det = 1'b0;
      stop_det  = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic do_reset();
      en = 1'b1;
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      exp_q.delete();
      obs_q.delete();
      exp_na_q.delete();
      obs_na_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({m_bit_cnt, m_frame_cnt, m_reg_full, m_frame_done, m_data_phase, m_ack_phase, m_busy} !== '0) begin
         failures++;
         $display("FAIL reset_main: got %h, required 0", {m_bit_cnt, m_frame_cnt, m_reg_full, m_frame_done, m_data_phase, m_ack_phase, m_busy});
      end
      checks++;
      if ({s_bit_cnt, s_frame_cnt, s_reg_full, s_frame_done, s_data_phase, s_ack_phase, s_busy} !== '0) begin
         failures++;
         $display("FAIL reset_sat: got %h, required 0", {s_bit_cnt, s_frame_cnt, s_reg_full, s_frame_done, s_data_phase, s_ack_phase, s_busy});
      end
      checks++;
      if ({n_bit_cnt, n_frame_cnt, n_reg_full, n_frame_done, n_data_phase, n_ack_phase, n_busy} !== '0) begin
         failures++;
         $display("FAIL reset_noack: got %h, required 0", {n_bit_cnt, n_frame_cnt, n_reg_full, n_frame_done, n_data_phase, n_ack_phase, n_busy});
      end
   endtask

   task automatic drain_main(input string name);
      ev_t e, o;
      int  n;
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL %s_pulse[%0d]: got no pulse, required %h", name, k, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               failures++;
               $display("FAIL %s_pulse[%0d]: got %h, required %h", name, k, o, e);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL %s_extra_pulses: got %0d extra (first %h), required 0", name, obs_q.size(), obs_q[0]);
      end
   endtask

   task automatic test_nominal();
      logic [3:0] exp_b;
      do_reset();
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({m_busy, m_data_phase, m_ack_phase, m_bit_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL nominal_start: got %b, required 110_0000", {m_busy, m_data_phase, m_ack_phase, m_bit_cnt});
      end
      for (int i = 1; i <= 9; i++) begin
         if (i == 8) exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 4'd8, 8'd0, 1'b1));
         if (i == 9) exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
         exp_b = (i == 9) ? 4'd0 : 4'(i);
         checks++;
         if (m_bit_cnt !== exp_b) begin
            failures++;
            $display("FAIL nominal_bit_cnt[%0d]: got %0d, required %0d", i, m_bit_cnt, exp_b);
         end
         clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
         clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
      drain_main("nominal");
   endtask

   task automatic test_back_to_back();
      int a0;
      do_reset();
      a0 = adj_cnt;
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 27; i++) begin
         if (i % 9 == 8) exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 4'd8, 8'(i / 9), 1'b1));
         if (i % 9 == 0) exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 4'd0, 8'(i / 9), 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (m_frame_cnt !== 8'd3) begin
         failures++;
         $display("FAIL b2b_frame_cnt: got %0d, required 3", m_frame_cnt);
      end
      checks++;
      if (adj_cnt !== a0) begin
         failures++;
         $display("FAIL b2b_adjacent_pulses: got %0d, required 0", adj_cnt - a0);
      end
      drain_main("b2b");
   endtask

   task automatic test_repeated_start();
      do_reset();
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         if (i == 8) exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 4'd8, 8'd0, 1'b1));
         if (i == 9) exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 1; i <= 5; i++) clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({m_bit_cnt, m_frame_cnt} !== {4'd5, 8'd1}) begin
         failures++;
         $display("FAIL rstart_before: got bit_cnt=%0d frame_cnt=%0d, required 5 and 1", m_bit_cnt, m_frame_cnt);
      end
      clk_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({m_bit_cnt, m_frame_cnt, m_data_phase, m_busy} !== {4'd0, 8'd0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL rstart_after: got bit_cnt=%0d frame_cnt=%0d data=%b busy=%b, required 0 0 1 1",
                  m_bit_cnt, m_frame_cnt, m_data_phase, m_busy);
      end
      for (int i = 1; i <= 9; i++) begin
         if (i == 8) exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 4'd8, 8'd0, 1'b1));
         if (i == 9) exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      drain_main("rstart");
   endtask

   task automatic test_stop_collision();
      do_reset();
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         if (i == 8) exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 4'd8, 8'd0, 1'b1));
         if (i == 9) exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 1; i <= 7; i++) clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (m_bit_cnt !== 4'd7) begin
         failures++;
         $display("FAIL stop_pre_bit_cnt: got %0d, required 7", m_bit_cnt);
      end
      clk_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({m_busy, m_data_phase, m_ack_phase, m_bit_cnt, m_frame_cnt} !== {3'b000, 4'd0, 8'd1}) begin
         failures++;
         $display("FAIL stop_state: got busy=%b data=%b ack=%b bit_cnt=%0d frame_cnt=%0d, required 0 0 0 0 1",
                  m_busy, m_data_phase, m_ack_phase, m_bit_cnt, m_frame_cnt);
      end
      clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({m_busy, m_bit_cnt, m_frame_cnt} !== {1'b0, 4'd0, 8'd1}) begin
         failures++;
         $display("FAIL idle_tick_ignored: got busy=%b bit_cnt=%0d frame_cnt=%0d, required 0 0 1",
                  m_busy, m_bit_cnt, m_frame_cnt);
      end
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      drain_main("stop");
   endtask

   task automatic test_en_saturation();
      logic [1:0] exp_f;
      do_reset();
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      en = 1'b0;
      for (int i = 1; i <= 10; i++) clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({s_bit_cnt, s_data_phase, s_busy} !== {4'd3, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL en_freeze: got bit_cnt=%0d data=%b busy=%b, required 3 1 1", s_bit_cnt, s_data_phase, s_busy);
      end
      en = 1'b1;
      for (int i = 1; i <= 6; i++) clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({s_frame_cnt, s_bit_cnt} !== {2'd1, 4'd0}) begin
         failures++;
         $display("FAIL en_resume: got frame_cnt=%0d bit_cnt=%0d, required 1 0", s_frame_cnt, s_bit_cnt);
      end
      for (int f = 2; f <= 5; f++) begin
         for (int i = 1; i <= 9; i++) clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
         exp_f = (f > 3) ? 2'd3 : 2'(f);
         checks++;
         if (s_frame_cnt !== exp_f) begin
            failures++;
            $display("FAIL sat_frame_cnt[%0d]: got %0d, required %0d", f, s_frame_cnt, exp_f);
         end
      end
   endtask

   task automatic test_reset_mid_ack();
      do_reset();
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 17; i++) begin
         if (i == 8 || i == 17) exp_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b0, 4'd8, 8'(i / 9), 1'b1));
         if (i == 9) exp_q.push_back(mk_ev(cyc + 1, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if ({m_ack_phase, m_bit_cnt, m_frame_cnt} !== {1'b1, 4'd8, 8'd1}) begin
         failures++;
         $display("FAIL mid_ack_pre: got ack=%b bit_cnt=%0d frame_cnt=%0d, required 1 8 1", m_ack_phase, m_bit_cnt, m_frame_cnt);
      end
      clk_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({m_bit_cnt, m_frame_cnt, m_reg_full, m_frame_done, m_data_phase, m_ack_phase, m_busy} !== '0) begin
         failures++;
         $display("FAIL mid_ack_reset: got %h, required 0", {m_bit_cnt, m_frame_cnt, m_reg_full, m_frame_done, m_data_phase, m_ack_phase, m_busy});
      end
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      drain_main("mid_ack");
   endtask

   task automatic test_no_ack();
      ev_t e, o;
      int  n;
      do_reset();
      clk_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         if (i % 8 == 0) exp_na_q.push_back(mk_ev(cyc + 1, 1'b1, 1'b1, 4'd0, 8'(i / 8), 1'b0));
         clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 8) begin
            checks++;
            if ({n_data_phase, n_ack_phase, n_bit_cnt} !== {1'b1, 1'b0, 4'd0}) begin
               failures++;
               $display("FAIL noack_state: got data=%b ack=%b bit_cnt=%0d, required 1 0 0", n_data_phase, n_ack_phase, n_bit_cnt);
            end
         end
      end
      clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n = exp_na_q.size();
      for (int k = 0; k < n; k++) begin
         e = exp_na_q.pop_front();
         checks++;
         if (obs_na_q.size() == 0) begin
            failures++;
            $display("FAIL noack_pulse[%0d]: got no pulse, required %h", k, e);
         end else begin
            o = obs_na_q.pop_front();
            if (o !== e) begin
               failures++;
               $display("FAIL noack_pulse[%0d]: got %h, required %h", k, o, e);
            end
         end
      end
      checks++;
      if (obs_na_q.size() != 0) begin
         failures++;
         $display("FAIL noack_extra_pulses: got %0d extra, required 0", obs_na_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_repeated_start();
      test_stop_collision();
      test_en_saturation();
      test_reset_mid_ack();
      test_no_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
